// File: rtl/pixel_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_layer_sequencer
// Purpose  : Tracks the active pixel (row/col) from blank/vsync strobes,
//            runs the WAIT -> OPENING -> GAME screen-phase FSM and arbitrates
//            one palette index per pixel from the competing layer sources.
// Options  : SCORE_OVERLAY_EN - when defined, the score-digit layer takes
//            part in GAME arbitration between crest and cursor.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_layer_sequencer #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int OPEN_FRAMES = 300,
    parameter int TRACE_R0    = 40,
    parameter int TRACE_R1    = 439,
    parameter int TRACE_C0    = 120,
    parameter int TRACE_C1    = 519
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    input  logic       cBLANK_n,
    input  logic       cVS,
    input  logic       skip,
    input  logic       req_logo,
    input  logic       req_crest,
    input  logic       req_num,
    input  logic       req_cursor,
    input  logic       req_box,
    input  logic [7:0] idx_logo,
    input  logic [7:0] idx_crest,
    input  logic [7:0] idx_num,
    input  logic [7:0] idx_cursor,
    input  logic [7:0] idx_box,
    input  logic [7:0] idx_bg,
    output logic [8:0] row,
    output logic [9:0] col,
    output logic       in_trace,
    output logic [1:0] phase,
    output logic       frame_start,
    output logic [7:0] palette_idx
);

    localparam logic [1:0]  S_WAIT    = 2'd0;
    localparam logic [1:0]  S_OPENING = 2'd1;
    localparam logic [1:0]  S_GAME    = 2'd2;

    localparam logic [9:0]  C_COL_LAST  = 10'(H_ACTIVE - 1);
    localparam logic [8:0]  C_ROW_LAST  = 9'(V_ACTIVE - 1);
    localparam logic [15:0] C_OPEN_LAST = 16'(OPEN_FRAMES - 1);
    localparam logic [15:0] C_CNT_MAX   = 16'hFFFF;
    localparam logic [8:0]  C_TR_R0     = 9'(TRACE_R0);
    localparam logic [8:0]  C_TR_R1     = 9'(TRACE_R1);
    localparam logic [9:0]  C_TR_C0     = 10'(TRACE_C0);
    localparam logic [9:0]  C_TR_C1     = 10'(TRACE_C1);

    logic [8:0]  row_q, row_d;
    logic [9:0]  col_q, col_d;
    logic        cvs_q, cvs_d;
    logic        frame_start_q, frame_start_d;
    logic [1:0]  state_q, state_d;
    logic [15:0] fcnt_q, fcnt_d;
    logic        skip_q, skip_d;
    logic [7:0]  palette_idx_q, palette_idx_d;

`ifndef SCORE_OVERLAY_EN
    // Score layer is compiled out; its ports are tied into a dangling sink.
    logic w_unused_num;
    assign w_unused_num = ^{req_num, idx_num};
`endif

    // State register: every flop of the block, cleared asynchronously.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            row_q         <= '0;
            col_q         <= '0;
            cvs_q         <= 1'b1;   // idle-high history so a low cVS after reset counts as an edge
            frame_start_q <= 1'b0;
            state_q       <= S_WAIT;
            fcnt_q        <= '0;
            skip_q        <= 1'b0;
            palette_idx_q <= '0;
        end else begin
            row_q         <= row_d;
            col_q         <= col_d;
            cvs_q         <= cvs_d;
            frame_start_q <= frame_start_d;
            state_q       <= state_d;
            fcnt_q        <= fcnt_d;
            skip_q        <= skip_d;
            palette_idx_q <= palette_idx_d;
        end
    end

    // Pixel position: vsync low resets the raster, otherwise count active pixels.
    always_comb begin
        row_d         = row_q;
        col_d         = col_q;
        cvs_d         = cVS;
        frame_start_d = cvs_q & ~cVS;
        if (!cVS) begin
            row_d = '0;
            col_d = '0;
        end else if (cBLANK_n) begin
            if (col_q == C_COL_LAST) begin
                col_d = '0;
                row_d = (row_q == C_ROW_LAST) ? 9'd0 : row_q + 9'd1;
            end else begin
                col_d = col_q + 10'd1;
            end
        end
    end

    // Phase FSM next state: transitions only on the registered frame_start pulse.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        skip_d  = skip_q;
        case (state_q)
            S_WAIT: begin
                fcnt_d = '0;
                skip_d = 1'b0;
                if (frame_start_q) begin
                    state_d = S_OPENING;
                end
            end
            S_OPENING: begin
                if (skip) begin
                    skip_d = 1'b1;
                end
                if (frame_start_q) begin
                    // A latched skip and the terminal count resolve to one transition.
                    if (skip_q || (fcnt_q == C_OPEN_LAST)) begin
                        state_d = S_GAME;
                        skip_d  = 1'b0;
                    end else if (fcnt_q != C_CNT_MAX) begin
                        fcnt_d = fcnt_q + 16'd1;
                    end
                end
            end
            S_GAME: begin
                skip_d = 1'b0;
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    // Outputs: trace-window decode and per-phase layer priority.
    always_comb begin
        in_trace      = (row_q >= C_TR_R0) && (row_q <= C_TR_R1) &&
                        (col_q >= C_TR_C0) && (col_q <= C_TR_C1);
        palette_idx_d = 8'd0;
        if (cBLANK_n) begin
            case (state_q)
                S_OPENING: begin
                    if (req_logo && in_trace) begin
                        palette_idx_d = idx_logo;
                    end
                end
                S_GAME: begin
                    if (req_crest) begin
                        palette_idx_d = idx_crest;
`ifdef SCORE_OVERLAY_EN
                    end else if (req_num) begin
                        palette_idx_d = idx_num;
`endif
                    end else if (req_cursor && in_trace) begin
                        palette_idx_d = idx_cursor;
                    end else if (req_box && in_trace) begin
                        palette_idx_d = idx_box;
                    end else begin
                        palette_idx_d = idx_bg;
                    end
                end
                default: begin
                    palette_idx_d = 8'd0;
                end
            endcase
        end
    end

    assign row         = row_q;
    assign col         = col_q;
    assign phase       = state_q;
    assign frame_start = frame_start_q;
    assign palette_idx = palette_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_layer_sequencer
// Purpose  : Self-checking bench for pixel_layer_sequencer (OPEN_FRAMES=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_layer_sequencer;

    localparam int H  = 640;
    localparam int V  = 480;
    localparam int OF = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, blank_n, vs, skip;
    logic       req_logo, req_crest, req_num, req_cursor, req_box;
    logic [7:0] idx_logo, idx_crest, idx_num, idx_cursor, idx_box, idx_bg;
    logic [8:0] row;
    logic [9:0] col;
    logic       in_trace, frame_start;
    logic [1:0] phase;
    logic [7:0] palette_idx;

    int n_checks = 0;
    int n_fail   = 0;
    int tb_row   = 0;
    int tb_col   = 0;
    logic [7:0] sb_q[$];
    logic [7:0] exp_v;

    pixel_layer_sequencer #(
        .H_ACTIVE(H), .V_ACTIVE(V), .OPEN_FRAMES(OF),
        .TRACE_R0(40), .TRACE_R1(439), .TRACE_C0(120), .TRACE_C1(519)
    ) dut (
        .iVGA_CLK(clk), .iRST_n(rst_n), .cBLANK_n(blank_n), .cVS(vs), .skip(skip),
        .req_logo(req_logo), .req_crest(req_crest), .req_num(req_num),
        .req_cursor(req_cursor), .req_box(req_box),
        .idx_logo(idx_logo), .idx_crest(idx_crest), .idx_num(idx_num),
        .idx_cursor(idx_cursor), .idx_box(idx_box), .idx_bg(idx_bg),
        .row(row), .col(col), .in_trace(in_trace), .phase(phase),
        .frame_start(frame_start), .palette_idx(palette_idx)
    );

    // Expected arbitration result for the pixel currently presented.
    function automatic logic [7:0] model_idx(input int ph, input int r, input int c);
        bit tr;
        tr = (r >= 40) && (r <= 439) && (c >= 120) && (c <= 519);
        if (!blank_n || ph == 0) return 8'd0;
        if (ph == 1) return (req_logo && tr) ? idx_logo : 8'd0;
        if (req_crest) return idx_crest;
`ifdef SCORE_OVERLAY_EN
        if (req_num) return idx_num;
`endif
        if (req_cursor && tr) return idx_cursor;
        if (req_box && tr) return idx_box;
        return idx_bg;
    endfunction

    // One clock; outputs are sampled 1 ns after the edge, raster model follows the inputs.
    task automatic step();
        @(posedge clk);
        #1;
        if (!rst_n || !vs) begin
            tb_row = 0;
            tb_col = 0;
        end else if (blank_n) begin
            if (tb_col == H - 1) begin
                tb_col = 0;
                tb_row = (tb_row == V - 1) ? 0 : tb_row + 1;
            end else begin
                tb_col = tb_col + 1;
            end
        end
    endtask

    task automatic clear_reqs();
        {req_logo, req_crest, req_num, req_cursor, req_box} = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; vs = 1'b1; blank_n = 1'b0; skip = 1'b0;
        clear_reqs();
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic advance_to(input int r, input int c);
        blank_n = 1'b1;
        while (!(tb_row == r && tb_col == c)) step();
        blank_n = 1'b0;
    endtask

    // Single-cycle vsync with frame_start and phase checks around it.
    task automatic frame_pulse(input int ph_before, input int ph_after);
        vs = 1'b0;
        step();
        n_checks++;
        if (frame_start !== 1'b1) begin n_fail++; $display("FAIL fs_pulse: frame_start=%0b required 1", frame_start); end
        n_checks++;
        if (phase !== 2'(ph_before)) begin n_fail++; $display("FAIL fs_phase_hold: phase=%0d required %0d", phase, ph_before); end
        n_checks++;
        if (row !== 9'd0 || col !== 10'd0) begin n_fail++; $display("FAIL vs_clear: row=%0d col=%0d required 0/0", row, col); end
        vs = 1'b1;
        step();
        n_checks++;
        if (frame_start !== 1'b0) begin n_fail++; $display("FAIL fs_single: frame_start=%0b required 0", frame_start); end
        n_checks++;
        if (phase !== 2'(ph_after)) begin n_fail++; $display("FAIL fs_phase_next: phase=%0d required %0d", phase, ph_after); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vs = 1'b0; blank_n = 1'b1; skip = 1'b0;
        req_crest = 1'b1; req_logo = 1'b1; req_num = 1'b0; req_cursor = 1'b0; req_box = 1'b0;
        step(); step();
        n_checks++; if (row !== 9'd0)        begin n_fail++; $display("FAIL rst_row: %0d required 0", row); end
        n_checks++; if (col !== 10'd0)       begin n_fail++; $display("FAIL rst_col: %0d required 0", col); end
        n_checks++; if (in_trace !== 1'b0)   begin n_fail++; $display("FAIL rst_in_trace: %0b required 0", in_trace); end
        n_checks++; if (phase !== 2'd0)      begin n_fail++; $display("FAIL rst_phase: %0d required 0", phase); end
        n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL rst_fs: %0b required 0", frame_start); end
        n_checks++; if (palette_idx !== 8'd0) begin n_fail++; $display("FAIL rst_pidx: %0d required 0", palette_idx); end
        // vsync history resets high, so vsync already low at release is a frame edge.
        clear_reqs();
        rst_n = 1'b1;
        step();
        n_checks++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL rst_vs_hist: frame_start=%0b required 1", frame_start); end
        vs = 1'b1;
        step();
        n_checks++; if (phase !== 2'd1) begin n_fail++; $display("FAIL rst_first_open: phase=%0d required 1", phase); end
    endtask

    task automatic test_tracking();
        do_reset();
        blank_n = 1'b1;
        for (int i = 1; i <= H; i++) begin
            step();
            n_checks++;
            if (col !== 10'(i % H)) begin n_fail++; $display("FAIL track_col: col=%0d required %0d", col, i % H); end
            n_checks++;
            if (row !== 9'((i == H) ? 1 : 0)) begin n_fail++; $display("FAIL track_row: row=%0d required %0d at i=%0d", row, (i == H) ? 1 : 0, i); end
        end
        repeat (5) step();
        vs = 1'b0;
        step();
        n_checks++;
        if (row !== 9'd0 || col !== 10'd0) begin n_fail++; $display("FAIL vs_priority: row=%0d col=%0d required 0/0", row, col); end
        vs = 1'b1; blank_n = 1'b0;
        step();
    endtask

    task automatic test_phase_sequence();
        do_reset();
        n_checks++; if (phase !== 2'd0) begin n_fail++; $display("FAIL wait_phase: %0d required 0", phase); end
        skip = 1'b1; step(); skip = 1'b0;      // skip in WAIT must not shorten the opening
        repeat (10) step();
        n_checks++; if (phase !== 2'd0) begin n_fail++; $display("FAIL wait_hold: %0d required 0", phase); end
        frame_pulse(0, 1);
        repeat (20) step();
        frame_pulse(1, 1);
        repeat (20) step();
        frame_pulse(1, 2);
        skip = 1'b1; step(); skip = 1'b0;      // skip in GAME is ignored
        repeat (10) step();
        frame_pulse(2, 2);
    endtask

    task automatic test_opening_logo_and_skip();
        do_reset();
        frame_pulse(0, 1);
        idx_logo = 8'h5A; idx_crest = 8'd11; idx_num = 8'd44;
        idx_cursor = 8'd22; idx_box = 8'd33; idx_bg = 8'd7;
        advance_to(40, 118);
        blank_n = 1'b1;
        req_logo = 1'b1; req_crest = 1'b1; req_cursor = 1'b1; req_box = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) req_logo = 1'b0;
            sb_q.push_back(model_idx(1, tb_row, tb_col));
            step();
            exp_v = sb_q.pop_front();
            n_checks++;
            if (palette_idx !== exp_v) begin n_fail++; $display("FAIL open_arb[%0d]: palette_idx=%0d required %0d", k, palette_idx, exp_v); end
        end
        blank_n = 1'b0;
        clear_reqs();
        skip = 1'b1; step(); skip = 1'b0;
        repeat (30) step();
        n_checks++; if (phase !== 2'd1) begin n_fail++; $display("FAIL skip_midframe: phase=%0d required 1", phase); end
        frame_pulse(1, 2);                      // counter alone would not finish yet
    endtask

    task automatic test_game_priority();
        logic [3:0] pat[6];
        pat = '{4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b1111};
        advance_to(20, 60);
        n_checks++; if (row !== 9'd20 || col !== 10'd60) begin n_fail++; $display("FAIL pos_20_60: row=%0d col=%0d", row, col); end
        n_checks++; if (in_trace !== 1'b0) begin n_fail++; $display("FAIL trace_out: %0b required 0", in_trace); end
        blank_n = 1'b1; clear_reqs(); req_cursor = 1'b1;
        sb_q.push_back(model_idx(2, tb_row, tb_col));
        step();
        exp_v = sb_q.pop_front();
        n_checks++; if (palette_idx !== exp_v) begin n_fail++; $display("FAIL game_outside: palette_idx=%0d required %0d", palette_idx, exp_v); end
        clear_reqs();
        advance_to(50, 200);
        n_checks++; if (row !== 9'd50 || col !== 10'd200) begin n_fail++; $display("FAIL pos_50_200: row=%0d col=%0d", row, col); end
        n_checks++; if (in_trace !== 1'b1) begin n_fail++; $display("FAIL trace_in: %0b required 1", in_trace); end
        for (int i = 0; i < 6; i++) begin
            blank_n = (i != 5);
            {req_crest, req_num, req_cursor, req_box} = pat[i];
            sb_q.push_back(model_idx(2, tb_row, tb_col));
            step();
            exp_v = sb_q.pop_front();
            n_checks++;
            if (palette_idx !== exp_v) begin n_fail++; $display("FAIL game_arb[%0d]: palette_idx=%0d required %0d", i, palette_idx, exp_v); end
        end
        clear_reqs();
    endtask

    task automatic test_reset_mid_frame();
        blank_n = 1'b1; req_crest = 1'b1;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        n_checks++; if (phase !== 2'd0)       begin n_fail++; $display("FAIL mid_rst_phase: %0d required 0", phase); end
        n_checks++; if (row !== 9'd0 || col !== 10'd0) begin n_fail++; $display("FAIL mid_rst_pos: row=%0d col=%0d", row, col); end
        n_checks++; if (palette_idx !== 8'd0) begin n_fail++; $display("FAIL mid_rst_pidx: %0d required 0", palette_idx); end
        n_checks++; if (frame_start !== 1'b0 || in_trace !== 1'b0) begin n_fail++; $display("FAIL mid_rst_flags: fs=%0b tr=%0b", frame_start, in_trace); end
        step(); step();
        rst_n = 1'b1; blank_n = 1'b0; clear_reqs();
        step();
        n_checks++; if (phase !== 2'd0) begin n_fail++; $display("FAIL post_rst_wait: %0d required 0", phase); end
        frame_pulse(0, 1);
        repeat (10) step();
        frame_pulse(1, 1);                      // opening replays its full length
        repeat (10) step();
        frame_pulse(1, 2);
    endtask

    initial begin
        test_reset();
        test_tracking();
        test_phase_sequence();
        test_opening_logo_and_skip();
        test_game_priority();
        test_reset_mid_frame();
        n_checks++;
        if (sb_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d left required 0", sb_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/pixel_layer_sequencer.md
# pixel_layer_sequencer

Frame-synchronous sequencer and priority arbiter for the VGA pixel pipeline. It tracks the current pixel (row/col) from the sync generator's blank and vsync strobes. It runs the screen-phase state machine: wait for first frame, opening logo for a fixed number of frames, then game. Each cycle it selects exactly one palette index from the competing layer sources (logo, crest, score digits, cursor, traced box, background). The result feeds the colour-table ROM and replaces the tri-state index sharing in the controller.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- OPEN_FRAMES, 300, frames the opening logo is shown (5 s at 60 Hz)
- TRACE_R0 / TRACE_R1 / TRACE_C0 / TRACE_C1, 40 / 439 / 120 / 519, inclusive trace-window bounds

Ports:
- iVGA_CLK  in  1  pixel clock
- iRST_n  in  1  reset, asynchronous, active-low
- cBLANK_n  in  1  active-video strobe from sync generator
- cVS  in  1  vertical sync, active-low
- skip  in  1  single-cycle request to leave opening screen early
- req_logo, req_crest, req_num, req_cursor, req_box  in  1 each  layer wants this pixel
- idx_logo, idx_crest, idx_num, idx_cursor, idx_box, idx_bg  in  8 each  layer palette indices
- row  out  9  current active line, 0..V_ACTIVE-1
- col  out  10  current active pixel, 0..H_ACTIVE-1
- in_trace  out  1  (row,col) inside trace window
- phase  out  2  0 WAIT, 1 OPENING, 2 GAME
- frame_start  out  1  one-cycle pulse on cVS falling edge
- palette_idx  out  8  arbitrated index to colour ROM

## Operation
- Pixel tracking: col increments on each cycle with cBLANK_n=1; at H_ACTIVE-1 it wraps to 0 and row increments. row wraps from V_ACTIVE-1 to 0. cVS=0 forces row=col=0, with priority over counting.
- frame_start: cVS registered; pulse when previous=1 and current=0.
- FSM:
  - WAIT: entered on reset; goes to OPENING on the first frame_start; frame counter cleared.
  - OPENING: frame counter increments on each frame_start. Goes to GAME on the frame_start where the counter reaches OPEN_FRAMES-1, or on the next frame_start after a latched skip. Phase changes only at frame boundaries, never mid-frame.
  - GAME: terminal; only reset leaves it.
- skip is latched in OPENING and cleared on transition; skip in WAIT or GAME is ignored.
- Arbitration, combinational on current-cycle inputs, registered into palette_idx:
  - WAIT or cBLANK_n=0: 8'd0.
  - OPENING: logo if req_logo and in_trace, else 8'd0.
  - GAME, highest first: crest, num, cursor (requires in_trace), box (requires in_trace), idx_bg.
- req_logo is ignored in GAME; req_crest/num/cursor/box are ignored in OPENING.
- in_trace: combinational compare of registered row/col against the bounds, inclusive.
- Frame counter is 16 bits, saturating; OPEN_FRAMES must be ≤ 65535.

## Timing
- Reset values:
  - row 0, col 0, phase WAIT, frame_start 0, palette_idx 0.
  - in_trace reflects row=col=0, i.e. 0.
  - Internal cVS history reg resets to 1.
- row/col update 1 cycle after the qualifying cBLANK_n/cVS sample.
- in_trace is valid in the same cycle as row/col.
- palette_idx latency: 1 cycle from the layer requests/indices. Sources must present data aligned to the row/col they were given.
- frame_start is asserted the cycle after cVS is sampled low. A phase transition is visible on phase in the cycle after frame_start.
- Simultaneous skip and counter terminal on the same frame_start: go to GAME once, with no double transition.
- Reset mid-frame: all state returns to reset values immediately. The next frame_start re-enters OPENING; the opening screen replays in full.

## Configuration
- SCORE_OVERLAY_EN defined: the num layer participates in GAME arbitration between crest and cursor.
- Not defined: req_num and idx_num are unused (no logic). GAME priority becomes crest > cursor > box > bg.

## Test plan
- Reset then 3 frames with OPEN_FRAMES=2 -> phase WAIT until first frame_start, OPENING for 2 frames, GAME from third frame_start.
- Active video, cBLANK_n held 1 for 640 cycles -> col 0..639 then 0, row 0→1. cVS=0 mid-line -> row=col=0 next cycle.
- GAME, row=50, col=200, req_crest=req_cursor=req_box=1 with idx 11/22/33 -> palette_idx=11 one cycle later. Drop req_crest -> 22 (or the idx_num value if req_num=1 with SCORE_OVERLAY_EN).
- GAME, row=20, col=60 (outside trace), req_cursor=1 idx 22, idx_bg=7 -> palette_idx=7.
- OPENING, skip pulse mid-frame -> phase stays 1 until the next frame_start, then 2. Skip in GAME -> no change.
- Assert iRST_n=0 mid-frame while in GAME -> all outputs zero and phase=WAIT immediately. After release, first frame_start -> OPENING.
